// File: rtl/stt8_entity_pkg.sv
// Shared definitions for the entity table loader.
// Holds the receiver state encoding, header field constants, the slot count,
// entity word widths and the reset ("unused", ID 4'hF) words.
package stt8_entity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_D1,
    ST_D2,
    ST_D3
  } rx_state_t;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;
  localparam logic [3:0] CMD_COMMIT  = 4'h0;
  localparam logic [3:0] ARRAY_SLOT  = 4'd7;

  localparam int NUM_SLOTS = 9;
  localparam int WORD_W    = 14;
  localparam int ARRAY_W   = 18;

  localparam logic [WORD_W-1:0]  RESET_WORD  = 14'h3C00;
  localparam logic [ARRAY_W-1:0] RESET_ARRAY = 18'h3C000;

  // Commands 1..NUM_SLOTS address a slot; 0 is COMMIT, the rest are invalid.
  function automatic logic is_write_cmd(input logic [3:0] cmd);
    return (cmd != CMD_COMMIT) && (int'(cmd) <= NUM_SLOTS);
  endfunction

endpackage

// File: rtl/entity_pkt_rx.sv
// Packet receiver for the entity table loader.
// Parses header/data bytes, assembles slot words and reports results.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   byte_in          packet byte
//   byte_valid       byte_in consumed when high
//   busy             receiver is mid-packet (registered)
//   pkt_error        one-cycle pulse, bad header or timeout (registered)
//   wr_en            final byte of a write accepted this cycle
//   wr_slot          slot number 1..9 of the write
//   wr_word          assembled word (14-bit slots zero-extended)
//   commit_req       valid COMMIT header accepted this cycle
//
// state   | meaning
// ST_IDLE | waiting for a header byte
// ST_D1   | header accepted, waiting for first data byte
// ST_D2   | waiting for second data byte (final for 14-bit slots)
// ST_D3   | waiting for third data byte (slot 7 only)
module entity_pkt_rx
  import stt8_entity_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               busy,
  output logic               pkt_error,
  output logic               wr_en,
  output logic [3:0]         wr_slot,
  output logic [ARRAY_W-1:0] wr_word,
  output logic               commit_req
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  rx_state_t        state, state_d;
  logic [3:0]       slot_q, slot_d;
  logic [13:0]      hold_q, hold_d;   // word bits [17:4] gathered from D1/D2
  logic [CNT_W-1:0] idle_cnt, cnt_d;
  logic             err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      slot_q    <= 4'd0;
      hold_q    <= 14'd0;
      idle_cnt  <= '0;
      pkt_error <= 1'b0;
    end else begin
      state     <= state_d;
      slot_q    <= slot_d;
      hold_q    <= hold_d;
      idle_cnt  <= cnt_d;
      pkt_error <= err_d;
    end
  end

  always_comb begin
    state_d    = state;
    slot_d     = slot_q;
    hold_d     = hold_q;
    cnt_d      = idle_cnt;
    err_d      = 1'b0;
    wr_en      = 1'b0;
    commit_req = 1'b0;

    if (slot_q == ARRAY_SLOT) begin
      wr_word = {hold_q, byte_in[3:0]};
    end else begin
      wr_word = {4'h0, hold_q[13:8], byte_in};
    end

    if (state == ST_IDLE) begin
      if (byte_valid) begin
        if (byte_in[7:4] == SYNC_NIBBLE && byte_in[3:0] == CMD_COMMIT) begin
          commit_req = 1'b1;
        end else if (byte_in[7:4] == SYNC_NIBBLE && is_write_cmd(byte_in[3:0])) begin
          state_d = ST_D1;
          slot_d  = byte_in[3:0];
          cnt_d   = CNT_LOAD;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (byte_valid) begin
      cnt_d = CNT_LOAD;
      case (state)
        ST_D1: begin
          hold_d[13:8] = byte_in[5:0];
          state_d      = ST_D2;
        end
        ST_D2: begin
          hold_d[7:0] = byte_in;
          if (slot_q == ARRAY_SLOT) begin
            state_d = ST_D3;
          end else begin
            wr_en   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          wr_en   = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end else if (idle_cnt == '0) begin
      // Terminal count: the packet stalled for TIMEOUT_CYCLES cycles.
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else begin
      cnt_d = idle_cnt - CNT_W'(1);
    end
  end

  assign busy    = (state != ST_IDLE);
  assign wr_slot = slot_q;

endmodule

// File: rtl/entity_table_loader.sv
// Entity table loader: receives slot-write and COMMIT packets into a shadow
// table and copies the shadow table to the active table at frame start.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   byte_in, byte_valid        host byte stream
//   frame_start                start-of-vblank pulse
//   entity_1..6, entity_8_flip, entity_9_flip   active 14-bit words
//   entity_7_array             active 18-bit array word
//   busy                       receiver mid-packet
//   commit_pending             commit requested, not yet applied
//   pkt_error                  rejected/aborted packet pulse
module entity_table_loader
  import stt8_entity_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  input  logic               frame_start,
  output logic [WORD_W-1:0]  entity_1,
  output logic [WORD_W-1:0]  entity_2,
  output logic [WORD_W-1:0]  entity_3,
  output logic [WORD_W-1:0]  entity_4,
  output logic [WORD_W-1:0]  entity_5,
  output logic [WORD_W-1:0]  entity_6,
  output logic [ARRAY_W-1:0] entity_7_array,
  output logic [WORD_W-1:0]  entity_8_flip,
  output logic [WORD_W-1:0]  entity_9_flip,
  output logic               busy,
  output logic               commit_pending,
  output logic               pkt_error
);

  logic               wr_en;
  logic [3:0]         wr_slot;
  logic [ARRAY_W-1:0] wr_word;
  logic               commit_req;
  logic [2:0]         wr_idx;

  // 14-bit slots packed densely: slots 1..6 -> 0..5, slots 8,9 -> 6,7.
  logic [WORD_W-1:0]  shadow_word [NUM_SLOTS-1];
  logic [WORD_W-1:0]  active_word [NUM_SLOTS-1];
  logic [ARRAY_W-1:0] shadow_array, active_array;

  entity_pkt_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .busy      (busy),
    .pkt_error (pkt_error),
    .wr_en     (wr_en),
    .wr_slot   (wr_slot),
    .wr_word   (wr_word),
    .commit_req(commit_req)
  );

  assign wr_idx = (wr_slot > ARRAY_SLOT) ? 3'(wr_slot - 4'd2) : 3'(wr_slot - 4'd1);

  // Shadow write and active copy share an edge, so a copy coinciding with a
  // final data byte picks up the pre-write shadow contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        shadow_word[i] <= RESET_WORD;
        active_word[i] <= RESET_WORD;
      end
      shadow_array   <= RESET_ARRAY;
      active_array   <= RESET_ARRAY;
      commit_pending <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_slot == ARRAY_SLOT) begin
          shadow_array <= wr_word;
        end else begin
          shadow_word[wr_idx] <= wr_word[WORD_W-1:0];
        end
      end
      // A COMMIT arriving with frame_start defers the copy to the next frame.
      if (commit_req) begin
        commit_pending <= 1'b1;
      end else if (frame_start && commit_pending) begin
        active_word    <= shadow_word;
        active_array   <= shadow_array;
        commit_pending <= 1'b0;
      end
    end
  end

  assign entity_1       = active_word[0];
  assign entity_2       = active_word[1];
  assign entity_3       = active_word[2];
  assign entity_4       = active_word[3];
  assign entity_5       = active_word[4];
  assign entity_6       = active_word[5];
  assign entity_8_flip  = active_word[6];
  assign entity_9_flip  = active_word[7];
  assign entity_7_array = active_array;

endmodule

// File: doc/entity_table_loader.md
ENTITY_TABLE_LOADER -- requirements
Module: entity_table_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, idle cycles inside a packet before it is aborted.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port byte_in  input  8  packet byte from the host pins.
REQ-005 SHALL have port byte_valid  input  1  byte_in is consumed on every cycle this is high.
REQ-006 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-007 SHALL have ports entity_1..entity_6, entity_8_flip, entity_9_flip  output  14 each  active entity words {ID[13:10], orient[9:8], tile[7:0]}.
REQ-008 SHALL have port entity_7_array  output  18  active array-entity word.
REQ-009 SHALL have port busy  output  1  high whenever the receiver is not in IDLE.
REQ-010 SHALL have port commit_pending  output  1  commit requested, not yet applied.
REQ-011 SHALL have port pkt_error  output  1  one-cycle pulse on a rejected or aborted packet.

Function
REQ-012 SHALL keep a shadow table and an active table of nine slots; outputs SHALL drive only the active table, registered.
REQ-013 Header byte: [7:4] sync = 4'hA, [3:0] command; command 0 = COMMIT, 1..9 = write slot N, 10..15 invalid.
REQ-014 Receiver FSM states: IDLE, D1, D2, D3; a header is accepted only in IDLE.
REQ-015 Valid write header: IDLE->D1, slot latched; D1->D2; D2->IDLE for 14-bit slots; D2->D3->IDLE for slot 7.
REQ-016 14-bit slot packing: D1 byte[5:0] -> bits[13:8], D2 byte -> bits[7:0]; D1 byte[7:6] ignored.
REQ-017 Slot 7 packing: D1 byte[5:0] -> [17:12], D2 byte -> [11:4], D3 byte[3:0] -> [3:0]; D3 byte[7:4] ignored.
REQ-018 Shadow slot SHALL be written once, on the cycle the final byte is accepted; partial packets SHALL NOT modify the shadow.
REQ-019 COMMIT header SHALL set commit_pending the next cycle; FSM stays IDLE.
REQ-020 On frame_start with commit_pending=1, all nine shadow slots SHALL be copied to active in one cycle and commit_pending cleared.
REQ-021 frame_start with commit_pending=0 SHALL leave the active table unchanged.
REQ-022 Bad sync nibble or invalid command in IDLE: byte dropped, FSM stays IDLE, pkt_error pulses one cycle later.
REQ-023 Idle counter resets on every accepted byte; in D1/D2/D3, TIMEOUT_CYCLES consecutive cycles without byte_valid SHALL return FSM to IDLE, discard the packet, pulse pkt_error.
REQ-024 COMMIT header and frame_start in the same cycle: copy SHALL NOT occur this frame; commit_pending set, applied at the next frame_start.
REQ-025 Final data byte and frame_start with commit_pending=1 in same cycle: active table SHALL receive the pre-write shadow value; the new write reaches active only on a later commit.
REQ-026 frame_start SHALL NOT affect the receiver FSM or idle counter.

Reset
REQ-027 rst_n low SHALL asynchronously force FSM to IDLE, idle counter 0, busy=0, commit_pending=0, pkt_error=0.
REQ-028 Reset SHALL set every shadow and active 14-bit slot to 14'h3C00 and slot 7 to 18'h3C000 (ID 4'hF = unused).
REQ-029 Reset asserted mid-packet SHALL discard the packet with no shadow update and no pkt_error.

Structure
REQ-030 Shared package stt8_entity_pkg SHALL hold: FSM state enum, sync nibble 4'hA, COMMIT code, slot count 9, reset words 14'h3C00/18'h3C000, entity word widths.
REQ-031 One sub-module is natural: entity_pkt_rx (FSM, idle counter, byte assembly, emits slot index + assembled word + write strobe + commit strobe); tables stay in the parent.

Verification
REQ-032 Reset -> entity_1..6,8,9 = 14'h3C00, entity_7_array = 18'h3C000, busy=0, commit_pending=0.
REQ-033 Bytes A3,2D,47 then A0, frame_start -> entity_3 = 14'h2D47 after frame_start, unchanged before; commit_pending 1 then 0.
REQ-034 Bytes A7,3F,C5,9E, A0, frame_start -> entity_7_array = 18'h3FC5E (D3 upper nibble ignored).
REQ-035 Bytes B2 and AC -> two pkt_error pulses, busy stays 0, tables unchanged.
REQ-036 A4,11 then no byte_valid for 1023 cycles -> busy falls, pkt_error pulses; A0+frame_start -> entity_4 still 14'h3C00.
REQ-037 A0 coincident with frame_start -> no update that cycle; next frame_start applies shadow; rst_n low mid-packet (after A5,12) -> busy=0 immediately, no pkt_error.
